// File: rtl/led_fade_pkg.sv
// -----------------------------------------------------------------------------
// led_fade_pkg
// Shared constants for the LED breathe sequencer: phase encodings, phase
// width, default timing constants and a counter-width helper.
// -----------------------------------------------------------------------------
package led_fade_pkg;

    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [PHASE_W-1:0] ST_RISE    = 3'd1;
    localparam logic [PHASE_W-1:0] ST_HOLD_HI = 3'd2;
    localparam logic [PHASE_W-1:0] ST_FALL    = 3'd3;
    localparam logic [PHASE_W-1:0] ST_HOLD_LO = 3'd4;

    localparam int DEF_TICK_DIV        = 300000;
    localparam int DEF_HOLD_TICKS      = 64;
    localparam int DEF_DEBOUNCE_CYCLES = 65536;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_fade_ctrl_sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Brings one raw board switch into the clk domain through a 2-flop
// synchronizer. When SW_DEBOUNCE_EN is defined, a synchronized value is only
// accepted after DEBOUNCE_CYCLES consecutive cycles at that value; otherwise
// DEBOUNCE_CYCLES is ignored.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   i_sw    raw switch input
//   o_sw    synchronized (and optionally debounced) switch value, registered
// -----------------------------------------------------------------------------
module sw_debounce
    import led_fade_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw
);

    logic r_meta;
    logic r_sync;

    // two-flop synchronizer for the asynchronous switch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_stable;

    // accept a new value once it has differed from the accepted one for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old value restarts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_sync;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_sw = r_stable;
`else
    assign o_sw = r_sync;
`endif

endmodule

// File: rtl/led_fade_ctrl.sv
// -----------------------------------------------------------------------------
// led_fade_ctrl
// Breathe-profile sequencer feeding the PWM LED driver level input:
// ramp up, hold at full, ramp down, hold at off. Started/stopped by sw_run;
// sw_mode selects continuous (0) or single-shot (1) operation.
// Optional build macro: SW_DEBOUNCE_EN adds a switch debounce filter.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   sw_run   raw switch, 1 = run profile
//   sw_mode  raw switch, 0 = continuous, 1 = single-shot
//   level    PWM level (registered)
//   tick     one-cycle pulse per level step (registered)
//   busy     high whenever not IDLE (registered)
//   phase    current state encoding (registered)
// -----------------------------------------------------------------------------
module led_fade_ctrl
    import led_fade_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int HOLD_TICKS      = DEF_HOLD_TICKS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_run,
    input  logic               sw_mode,
    output logic [WIDTH-1:0]   level,
    output logic               tick,
    output logic               busy,
    output logic [PHASE_W-1:0] phase
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int HW = cnt_width(HOLD_TICKS);
    localparam logic [WIDTH-1:0] LVL_MAX = '1;

    logic               w_run_s;
    logic               w_mode_s;
    logic [PHASE_W-1:0] r_state;
    logic [WIDTH-1:0]   r_level;
    logic [PW-1:0]      r_presc;
    logic               r_tick;
    logic [HW-1:0]      r_hold;
    logic               r_armed;
    logic               r_busy;
    logic [PHASE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   w_level_nxt;
    logic [HW-1:0]      w_hold_nxt;
    logic               w_armed_nxt;
    logic               w_hold_done;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_run (
        .i_clk (clk),
        .i_rst (reset),
        .i_sw  (sw_run),
        .o_sw  (w_run_s)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_mode (
        .i_clk (clk),
        .i_rst (reset),
        .i_sw  (sw_mode),
        .o_sw  (w_mode_s)
    );

    // step prescaler: free-runs outside IDLE, tick follows the terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (r_presc == PW'(TICK_DIV - 1)) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    // hold exit: with no hold configured a hold state lasts one cycle, tick or not
    always_comb begin
        w_hold_done = 1'b0;
        if (HOLD_TICKS == 0) begin
            w_hold_done = 1'b1;
        end else begin
            w_hold_done = r_tick && (r_hold == HW'(HOLD_TICKS - 1));
        end
    end

    // next-state, level and hold-count logic
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                w_level_nxt = '0;
                w_hold_nxt  = '0;
                if (w_run_s && r_armed) begin
                    w_state_nxt = ST_RISE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RISE: begin
                // a dropped run switch fades out from the current level
                if (!w_run_s) begin
                    w_state_nxt = ST_FALL;
                end else if (r_tick && (r_level == LVL_MAX)) begin
                    w_state_nxt = ST_HOLD_HI;
                end else if (r_tick) begin
                    w_level_nxt = r_level + 1'b1;
                end else begin
                    w_state_nxt = ST_RISE;
                end
            end
            ST_HOLD_HI: begin
                if (!w_run_s || w_hold_done) begin
                    w_state_nxt = ST_FALL;
                    w_hold_nxt  = '0;
                end else if (r_tick) begin
                    w_hold_nxt  = r_hold + 1'b1;
                end else begin
                    w_hold_nxt  = r_hold;
                end
            end
            ST_FALL: begin
                if (r_tick && (r_level == '0)) begin
                    w_state_nxt = ST_HOLD_LO;
                end else if (r_tick) begin
                    w_level_nxt = r_level - 1'b1;
                end else begin
                    w_state_nxt = ST_FALL;
                end
            end
            ST_HOLD_LO: begin
                if (w_hold_done) begin
                    w_hold_nxt = '0;
                    if (w_run_s && !w_mode_s) begin
                        w_state_nxt = ST_RISE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_tick) begin
                    w_hold_nxt = r_hold + 1'b1;
                end else begin
                    w_hold_nxt = r_hold;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_level_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // re-arming: run low always re-arms; a single-shot profile disarms on exit
    always_comb begin
        w_armed_nxt = r_armed;
        if (!w_run_s) begin
            w_armed_nxt = 1'b1;
        end else if ((r_state == ST_HOLD_LO) && w_hold_done && w_mode_s) begin
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = r_armed;
        end
    end

    // sequencer registers; busy is taken from the next state so it moves with phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_level <= '0;
            r_hold  <= '0;
            r_armed <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_hold  <= w_hold_nxt;
            r_armed <= w_armed_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign level = r_level;
    assign tick  = r_tick;
    assign busy  = r_busy;
    assign phase = r_state;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_fade_ctrl
// Self-checking bench for led_fade_ctrl. Instance A uses WIDTH=4, TICK_DIV=4,
// HOLD_TICKS=2; instance B uses TICK_DIV=1, HOLD_TICKS=0. Expected per-step
// (phase, level) sequences are built as queues from the profile rules.
// -----------------------------------------------------------------------------
module tb_led_fade_ctrl;

    localparam int W    = 4;
    localparam int TD   = 4;
    localparam int HT   = 2;
    localparam int DB   = 8;
    localparam int MAXV = 15;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT  = 3 + DB;
`else
    localparam int LAT  = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         reset_a, run_a, mode_a, tick_a, busy_a;
    logic [W-1:0] level_a;
    logic [2:0]   phase_a;
    logic         reset_b, run_b, mode_b, tick_b, busy_b;
    logic [W-1:0] level_b;
    logic [2:0]   phase_b;

    led_fade_ctrl #(.WIDTH(W), .TICK_DIV(TD), .HOLD_TICKS(HT), .DEBOUNCE_CYCLES(DB)) dut_a (
        .clk(clk), .reset(reset_a), .sw_run(run_a), .sw_mode(mode_a),
        .level(level_a), .tick(tick_a), .busy(busy_a), .phase(phase_a)
    );

    led_fade_ctrl #(.WIDTH(W), .TICK_DIV(1), .HOLD_TICKS(0), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .reset(reset_b), .sw_run(run_b), .sw_mode(mode_b),
        .level(level_b), .tick(tick_b), .busy(busy_b), .phase(phase_b)
    );

    int checks = 0;
    int errors = 0;
    int last_tick = -1;

    typedef struct {
        int ph;
        int lv;
    } step_t;
    step_t exp_q[$];

    logic [2:0]   ph_s [0:119];
    logic         tk_s [0:119];
    logic [W-1:0] lv_s [0:119];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void push(input int ph, input int lv);
        step_t s;
        s.ph = ph;
        s.lv = lv;
        exp_q.push_back(s);
    endfunction

    // expected states after each tick, rising from from_lv through HOLD_HI into FALL
    function automatic void add_rise(input int from_lv);
        for (int v = from_lv + 1; v <= MAXV; v++) push(1, v);
        push(2, MAXV);
        for (int h = 1; h < HT; h++) push(2, MAXV);
        push(3, MAXV);
    endfunction

    // expected states after each tick, falling from from_lv through HOLD_LO to final_ph
    function automatic void add_fall(input int from_lv, input int final_ph);
        for (int v = from_lv - 1; v >= 0; v--) push(3, v);
        push(4, 0);
        for (int h = 1; h < HT; h++) push(4, 0);
        push(final_ph, 0);
    endfunction

    // follow n ticks of instance A, checking cadence and the state after each step
    task automatic walk(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int    w;
            step_t e;
            w = 0;
            while (tick_a !== 1'b1 && w < 2 * TD + 2) begin
                @(negedge clk);
                w++;
            end
            chk({tag, "_tick"}, tick_a, 1);
            if (last_tick >= 0) chk({tag, "_tick_gap"}, cyc - last_tick, TD);
            last_tick = cyc;
            @(negedge clk);
            chk({tag, "_tick_pulse"}, tick_a, 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_phase"}, phase_a, e.ph);
                chk({tag, "_level"}, level_a, e.lv);
            end else begin
                chk({tag, "_model_empty"}, 1, 0);
            end
        end
    endtask

    // run has just been raised at a negedge: busy must rise exactly LAT cycles later
    task automatic wait_start(input string tag);
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_busy_early"}, busy_a, 0);
        @(negedge clk);
        chk({tag, "_busy"}, busy_a, 1);
        chk({tag, "_phase"}, phase_a, 1);
        chk({tag, "_level"}, level_a, 0);
        last_tick = -1;
        exp_q.delete();
    endtask

    initial begin
        int k, lvl, nbad, nent, prev, n_hi;
        reset_a = 1'b1; run_a = 1'b0; mode_a = 1'b0;
        reset_b = 1'b1; run_b = 1'b0; mode_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", level_a, 0);
        chk("rst_tick", tick_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_phase", phase_a, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_run", busy_a, 0);

`ifdef SW_DEBOUNCE_EN
        // short glitch must be filtered out
        run_a = 1'b1;
        repeat (5) @(negedge clk);
        run_a = 1'b0;
        n_hi = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy_a === 1'b1) n_hi++;
        end
        chk("db_glitch_ignored", n_hi, 0);
        // 10-cycle pulse starts RISE at cycle 2+8+1
        run_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("db_busy_early", busy_a, 0);
        run_a = 1'b0;
        @(negedge clk);
        chk("db_busy", busy_a, 1);
        chk("db_phase", phase_a, 1);
        k = 0;
        while (busy_a !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("db_back_idle", busy_a, 0);
`else
        // continuous breathe: two full periods
        run_a = 1'b1;
        wait_start("cont_start");
        add_rise(0); add_fall(MAXV, 1);
        walk(36, "cont1");
        add_rise(0); add_fall(MAXV, 1);
        walk(36, "cont2");

        // single-shot: mode changes mid-profile, only sampled at HOLD_LO exit
        mode_a = 1'b1;
        add_rise(0); add_fall(MAXV, 0);
        walk(36, "single");
        repeat (40) @(negedge clk);
        chk("single_no_restart_busy", busy_a, 0);
        chk("single_no_restart_phase", phase_a, 0);
        chk("single_no_restart_level", level_a, 0);
        run_a = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        run_a = 1'b1;
        wait_start("rearm");

        // drop run in RISE at level 7
        for (int v = 1; v <= 7; v++) push(1, v);
        walk(7, "pre_drop7");
        run_a = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("drop7_phase", phase_a, 3);
        chk("drop7_level", level_a, 7);
        add_fall(7, 0);
        walk(7 + HT + 1, "drop7");
        chk("drop7_idle", busy_a, 0);

        // random drop points anywhere in RISE or HOLD_HI
        mode_a = 1'b0;
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(MAXV + HT, 1);
            lvl = (k > MAXV) ? MAXV : k;
            run_a = 1'b1;
            wait_start("rnd_start");
            add_rise(0);
            walk(k, "rnd_pre");
            exp_q.delete();
            run_a = 1'b0;
            repeat (LAT) @(negedge clk);
            chk("rnd_drop_phase", phase_a, 3);
            chk("rnd_drop_level", level_a, lvl);
            add_fall(lvl, 0);
            walk(lvl + HT + 1, "rnd_fall");
            chk("rnd_idle", busy_a, 0);
            repeat (2) @(negedge clk);
        end

        // asynchronous reset mid-FALL at level 9
        run_a = 1'b1;
        wait_start("rst_run");
        add_rise(0);
        for (int v = MAXV - 1; v >= 9; v--) push(3, v);
        walk(18 + 6, "to_fall9");
        #2 reset_a = 1'b1;
        #1;
        chk("async_rst_level", level_a, 0);
        chk("async_rst_tick", tick_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_phase", phase_a, 0);
        @(negedge clk);
        reset_a = 1'b0;
        wait_start("rst_restart");
        push(1, 1); push(1, 2);
        walk(2, "rst_restart");

        // instance B: tick every cycle, single-cycle holds
        run_b = 1'b1;
        repeat (LAT) @(negedge clk);
        chk("b_start_phase", phase_b, 1);
        for (int i = 0; i < 120; i++) begin
            ph_s[i] = phase_b;
            tk_s[i] = tick_b;
            lv_s[i] = level_b;
            @(negedge clk);
        end
        nbad = 0;
        for (int i = 1; i < 120; i++) if (tk_s[i] !== 1'b1) nbad++;
        chk("b_tick_every_cycle", nbad, 0);
        chk("b_rise_top_level", lv_s[16], MAXV);
        chk("b_rise_top_phase", ph_s[16], 1);
        chk("b_hold_hi", ph_s[17], 2);
        chk("b_hold_hi_one_cycle", ph_s[18], 3);
        chk("b_hold_lo", ph_s[34], 4);
        chk("b_restart", ph_s[35], 1);
        nent = 0;
        prev = -1;
        for (int i = 1; i < 120; i++) begin
            if (ph_s[i-1] == 3'd4 && ph_s[i] == 3'd1) begin
                if (prev >= 0) chk("b_period", i - prev, 2 * MAXV + 2 + 2);
                prev = i;
                nent++;
            end
        end
        chk("b_restarts", nent, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_fade_ctrl.md
# led_fade_ctrl

Sequencer that drives the brightness level input of the board's PWM LED driver. It generates a timed breathe profile: ramp up, hold at full, ramp down, hold at off. The profile is started and stopped by the board switches. The block sits between the switch inputs and the PWM module, replacing the free-running sawtooth-to-triangle counter with an explicit state machine.

## Interface
- WIDTH, 8, level width; MAX = 2**WIDTH-1
- TICK_DIV, 300000, clk cycles per level step (>=1)
- HOLD_TICKS, 64, steps spent in each hold state (0 = no hold)
- DEBOUNCE_CYCLES, 65536, stable cycles required on a switch (only with debounce compiled in)

Ports:
- clk  in  1  system clock (60 MHz PLL output)
- reset  in  1  asynchronous, active-high reset
- sw_run  in  1  raw switch; 1 = run profile
- sw_mode  in  1  raw switch; 0 = continuous breathe, 1 = single-shot
- level  out  WIDTH  PWM level for the driver
- tick  out  1  one-cycle pulse per step
- busy  out  1  high in any state other than IDLE
- phase  out  3  current state encoding

## Operation
- Both switches pass through a 2-flop synchronizer, giving run_s and mode_s.
- Prescaler:
  - Counts 0..TICK_DIV-1 while not IDLE; held at 0 in IDLE.
  - tick is registered and asserts for the cycle after the count reaches TICK_DIV-1; the count wraps to 0.
- Hold counter: counts ticks within the hold states.
- States (phase): IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.
- IDLE:
  - level=0.
  - Go to RISE when run_s=1 and armed=1.
- RISE:
  - On tick, level+1.
  - On tick with level==MAX, go to HOLD_HI; level stays MAX, no overflow.
- HOLD_HI: after HOLD_TICKS ticks, go to FALL.
- FALL:
  - On tick, level-1.
  - On tick with level==0, go to HOLD_LO; no underflow.
- HOLD_LO: after HOLD_TICKS ticks:
  - Go to RISE if run_s=1 and mode_s=0.
  - Otherwise go to IDLE.
- run_s falling:
  - In RISE or HOLD_HI: go to FALL on the next cycle; level is preserved, giving a graceful fade-out.
  - In FALL or HOLD_LO: no effect; the profile ends normally in IDLE.
- armed:
  - Set in reset and whenever run_s=0.
  - Cleared on leaving HOLD_LO in single-shot mode.
  - A single-shot profile therefore needs run to drop and rise again before it restarts.
- mode_s is sampled only at HOLD_LO exit.
- HOLD_TICKS=0: hold states last exactly one cycle and do not wait for a tick.

## Timing
- Reset values: level=0, tick=0, busy=0, phase=0 (IDLE), prescaler=0, hold counter=0, armed=1.
- Reset mid-operation returns to these values immediately, asynchronously.
- Switch edge to state change:
  - 3 cycles: 2 synchronizer flops plus 1 FSM register.
  - Add DEBOUNCE_CYCLES when debounce is compiled in.
- Step latency: level updates on the same clock edge that ends the tick-high cycle.
- Full ramp length: MAX*TICK_DIV cycles.
- Full continuous period: (2*MAX+2+2*HOLD_TICKS)*TICK_DIV cycles, approximately.
- busy and phase are registered; they change on the same edge as the state.
- level, tick, busy and phase are all registered outputs with no combinational path from the inputs.

## Configuration
- SW_DEBOUNCE_EN
  - Defined: after synchronizing, each switch value is accepted only after DEBOUNCE_CYCLES consecutive cycles at that value.
  - Undefined: only the 2-flop synchronizer is present, and DEBOUNCE_CYCLES is ignored.

## Structure
- Package led_fade_pkg holds:
  - state encodings IDLE..HOLD_LO
  - the 3-bit phase width
  - the default TICK_DIV and HOLD_TICKS constants
- Sub-module sw_debounce: synchronizer plus the optional debounce counter, instantiated once per switch.

## Test plan
All cases use WIDTH=4 (MAX=15), TICK_DIV=4, HOLD_TICKS=2, without SW_DEBOUNCE_EN unless stated.
- Reset, then sw_run=1, sw_mode=0:
  - busy rises 3 cycles later.
  - level steps 0->15 with one step per tick, every 4 cycles.
  - level holds 15 for 2 ticks, falls to 0, holds 0 for 2 ticks, then restarts RISE.
  - No value outside 0..15 appears.
- sw_mode=1, sw_run held high:
  - One profile runs, then IDLE with level=0 and busy=0, and no restart.
  - Toggling sw_run 0->1 starts a new profile.
- Drop sw_run while in RISE at level=7:
  - phase=FALL on the next cycle after synchronization.
  - level falls 7->0, then HOLD_LO, then IDLE.
- Assert reset asynchronously in FALL at level=9 (mid-cycle):
  - All outputs show reset values before the next clk edge.
  - After release with sw_run=1, the profile restarts from 0.
- TICK_DIV=1, HOLD_TICKS=0:
  - tick is high every cycle.
  - Hold states last one cycle each.
  - One continuous period is 2*15+2 steps plus the hold cycles.
- With SW_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
  - A 5-cycle glitch on sw_run causes no state change.
  - A 10-cycle pulse starts RISE at cycle 2+8+1.
